// File: rtl/registro_universal_n.sv
`default_nettype none
// ============================================================================
// registro_universal_n : N-bit universal shift register with multi-step runs
// Optional rotate modes via SHREG_ROTATE_EN.    Revision: 1.0
// ============================================================================
module registro_universal_n #(
  parameter int                WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '1,
  parameter int                CNT_W     = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sr_in,
  input  logic             sl_in,
  input  logic [WIDTH-1:0] p_in,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic             so_r,
  output logic             so_l,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MAX_STEPS = CNT_W'(WIDTH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             dir_r;
  logic [WIDTH-1:0] q_op;
  logic [WIDTH-1:0] q_step;
  logic [CNT_W-1:0] amt_clamped;

  assign so_r = q[0];
  assign so_l = q[WIDTH-1];
  assign busy = (state == RUN);

  assign amt_clamped = (amount > MAX_STEPS) ? MAX_STEPS : amount;
  assign q_step      = dir_r ? {q[WIDTH-2:0], sl_in} : {sr_in, q[WIDTH-1:1]};

  always_comb begin
    q_op = q;
    case (mode)
      3'b001:  q_op = {sr_in, q[WIDTH-1:1]};
      3'b010:  q_op = {q[WIDTH-2:0], sl_in};
      3'b011:  q_op = p_in;
`ifdef SHREG_ROTATE_EN
      3'b100:  q_op = {q[0], q[WIDTH-1:1]};
      3'b101:  q_op = {q[WIDTH-2:0], q[WIDTH-1]};
`endif
      3'b110:  q_op = {q[WIDTH-1], q[WIDTH-1:1]};
      default: q_op = q;
    endcase
  end

  // done defaults low every edge so it can only ever be a one-cycle pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q     <= RESET_VAL;
      state <= IDLE;
      cnt   <= '0;
      dir_r <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            if (start) begin
              cnt   <= amt_clamped;
              dir_r <= dir;
              state <= RUN;
            end else begin
              q <= q_op;
            end
          end
          RUN: begin
            if (cnt != '0) begin
              q   <= q_step;
              cnt <= cnt - CNT_W'(1);
            end else begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_registro_universal_n.sv
`default_nettype none
// Directed self-checking bench for registro_universal_n (WIDTH=8).
module tb_registro_universal_n;

  logic       clock = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] mode;
  logic       sr_in, sl_in;
  logic [7:0] p_in;
  logic       start, dir;
  logic [3:0] amount;
  logic [7:0] q;
  logic       so_r, so_l, busy, done;

  int checks   = 0;
  int failures = 0;

  registro_universal_n #(.WIDTH(8)) dut (
    .clock(clock), .reset(reset), .en(en), .mode(mode),
    .sr_in(sr_in), .sl_in(sl_in), .p_in(p_in),
    .start(start), .dir(dir), .amount(amount),
    .q(q), .so_r(so_r), .so_l(so_l), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    mode = 3'b011; p_in = v; start = 1'b0; en = 1'b1;
    tick();
    mode = 3'b000;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (q !== 8'hFF) begin failures++; $display("FAIL por_q: got %h want ff", q); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++;
      $display("FAIL por_status: busy=%b done=%b want 0 0", busy, done); end
    @(negedge clock);
    reset = 1'b0;
    tick();
    load(8'h3C);
    checks++; if (q !== 8'h3C) begin failures++; $display("FAIL load_3c: got %h want 3c", q); end
    #2 reset = 1'b1;
    #1;
    checks++; if (q !== 8'hFF) begin failures++; $display("FAIL async_rst_q: got %h want ff", q); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++;
      $display("FAIL async_rst_status: busy=%b done=%b want 0 0", busy, done); end
    #1 reset = 1'b0;
  endtask

  task automatic test_shift();
    load(8'hA5);
    checks++; if (q !== 8'hA5) begin failures++; $display("FAIL load_a5: got %h want a5", q); end
    checks++; if (so_r !== 1'b1 || so_l !== 1'b1) begin failures++;
      $display("FAIL so_a5: so_r=%b so_l=%b want 1 1", so_r, so_l); end
    mode = 3'b001; sr_in = 1'b0;
    tick();
    checks++; if (q !== 8'h52) begin failures++; $display("FAIL shr: got %h want 52", q); end
    checks++; if (so_r !== 1'b0 || so_l !== 1'b0) begin failures++;
      $display("FAIL so_52: so_r=%b so_l=%b want 0 0", so_r, so_l); end
    mode = 3'b010; sl_in = 1'b1;
    tick();
    checks++; if (q !== 8'hA5) begin failures++; $display("FAIL shl: got %h want a5", q); end
    en = 1'b0; mode = 3'b001; sr_in = 1'b0;
    tick();
    checks++; if (q !== 8'hA5) begin failures++; $display("FAIL en_hold: got %h want a5", q); end
    en = 1'b1; mode = 3'b111;
    tick();
    checks++; if (q !== 8'hA5) begin failures++; $display("FAIL mode7_hold: got %h want a5", q); end
    mode = 3'b000; sl_in = 1'b0;
  endtask

  task automatic test_asr();
    load(8'h80);
    mode = 3'b110;
    tick();
    checks++; if (q !== 8'hC0) begin failures++; $display("FAIL asr1: got %h want c0", q); end
    tick();
    checks++; if (q !== 8'hE0) begin failures++; $display("FAIL asr2: got %h want e0", q); end
    mode = 3'b000;
  endtask

  task automatic test_run();
    logic [7:0] exp_q [3] = '{8'h52, 8'h29, 8'h14};
    load(8'hA5);
    start = 1'b1; amount = 4'd3; dir = 1'b0; sr_in = 1'b0;
    tick();
    checks++; if (busy !== 1'b1 || q !== 8'hA5) begin failures++;
      $display("FAIL run_enter: busy=%b q=%h want 1 a5", busy, q); end
    // mode/start activity during RUN must not disturb the run
    start = 1'b0; mode = 3'b011; p_in = 8'h00; amount = 4'd9; dir = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (q !== exp_q[i] || busy !== 1'b1 || done !== 1'b0) begin failures++;
        $display("FAIL run_step%0d: q=%h busy=%b done=%b want %h 1 0", i, q, busy, done, exp_q[i]); end
    end
    mode = 3'b000;
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b1 || q !== 8'h14) begin failures++;
      $display("FAIL run_exit: busy=%b done=%b q=%h want 0 1 14", busy, done, q); end
    tick();
    checks++; if (done !== 1'b0 || q !== 8'h14) begin failures++;
      $display("FAIL run_done_pulse: done=%b q=%h want 0 14", done, q); end
  endtask

  task automatic test_stall();
    int n;
    load(8'hA5);
    start = 1'b1; amount = 4'd3; dir = 1'b0; sr_in = 1'b0;
    tick();
    start = 1'b0;
    tick();
    checks++; if (q !== 8'h52) begin failures++; $display("FAIL stall_pre: got %h want 52", q); end
    en = 1'b0;
    tick();
    tick();
    checks++; if (q !== 8'h52 || busy !== 1'b1 || done !== 1'b0) begin failures++;
      $display("FAIL stall_frozen: q=%h busy=%b done=%b want 52 1 0", q, busy, done); end
    en = 1'b1;
    n = 4;
    while (busy === 1'b1 && n < 30) begin tick(); if (busy === 1'b1) n++; end
    checks++; if (n != 6) begin failures++; $display("FAIL stall_busy_len: got %0d want 6", n); end
    checks++; if (q !== 8'h14 || done !== 1'b1) begin failures++;
      $display("FAIL stall_final: q=%h done=%b want 14 1", q, done); end
  endtask

  task automatic test_rotate_and_bounds();
    int n;
    load(8'h81);
    mode = 3'b100;
    tick();
`ifdef SHREG_ROTATE_EN
    checks++; if (q !== 8'hC0) begin failures++; $display("FAIL rotr: got %h want c0", q); end
`else
    checks++; if (q !== 8'h81) begin failures++; $display("FAIL rotr_off: got %h want 81", q); end
`endif
    mode = 3'b000;
    load(8'h81);
    start = 1'b1; amount = 4'd0;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++;
      $display("FAIL amt0_run: busy=%b done=%b want 1 0", busy, done); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b1 || q !== 8'h81) begin failures++;
      $display("FAIL amt0_exit: busy=%b done=%b q=%h want 0 1 81", busy, done, q); end
    load(8'hFF);
    start = 1'b1; amount = 4'd12; dir = 1'b1; sl_in = 1'b0;
    tick();
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 30) begin n++; tick(); end
    checks++; if (n != 9) begin failures++; $display("FAIL clamp_busy_len: got %0d want 9", n); end
    checks++; if (q !== 8'h00 || done !== 1'b1) begin failures++;
      $display("FAIL clamp_final: q=%h done=%b want 00 1", q, done); end
  endtask

  task automatic test_reset_in_run();
    int seen_done;
    load(8'hA5);
    start = 1'b1; amount = 4'd3; dir = 1'b0; sr_in = 1'b0;
    tick();
    start = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    checks++; if (q !== 8'hFF || busy !== 1'b0 || done !== 1'b0) begin failures++;
      $display("FAIL rst_run: q=%h busy=%b done=%b want ff 0 0", q, busy, done); end
    #1 reset = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) seen_done++;
    end
    checks++; if (seen_done != 0 || q !== 8'hFF) begin failures++;
      $display("FAIL rst_run_after: status_hits=%0d q=%h want 0 ff", seen_done, q); end
    load(8'h5A);
    checks++; if (q !== 8'h5A) begin failures++; $display("FAIL post_rst_load: got %h want 5a", q); end
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; mode = 3'b000; sr_in = 1'b0; sl_in = 1'b0;
    p_in = 8'h00; start = 1'b0; dir = 1'b0; amount = 4'd0;
    test_reset();
    test_shift();
    test_asr();
    test_run();
    test_stall();
    test_rotate_and_bounds();
    test_reset_in_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/registro_universal_n.md
REGISTRO_UNIVERSAL_N -- requirements
Module: registro_universal_n

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (>=2); bit WIDTH-1 is MSB.
REQ-002 Parameter RESET_VAL, default all ones, value loaded into q on reset.
REQ-003 Parameter CNT_W, default $clog2(WIDTH)+1, width of amount and the internal step counter.
REQ-004 clock  in  1  rising-edge clock, sole clock domain.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 en  in  1  clock enable; 0 = hold q and stall any run in progress.
REQ-007 mode  in  3  single-cycle operation select (REQ-012).
REQ-008 sr_in, sl_in  in  1 each  serial inputs: sr_in enters MSB on right shift; sl_in enters LSB on left shift.
REQ-009 p_in  in  WIDTH  parallel load data.
REQ-010 start, dir, amount  in  1, 1, CNT_W  multi-step request; dir 0 = right, 1 = left; amount = step count.
REQ-011 q  out  WIDTH register contents; so_r, so_l  out  1 each  = q[0], q[WIDTH-1] (combinational); busy, done  out  1 each  run status.

Function
REQ-012 mode when idle and en=1: 000 hold; 001 shift right; 010 shift left; 011 load p_in; 100 rotate right; 101 rotate left; 110 arithmetic shift right (MSB replicated); 111 hold (reserved).
REQ-013 Single-cycle operations take effect at the rising edge where sampled; q updates with 1-cycle latency.
REQ-014 FSM states IDLE and RUN; busy=1 exactly while in RUN.
REQ-015 IDLE with start=1 and en=1: load counter with min(amount, WIDTH), enter RUN, latch dir; mode ignored that cycle (start has priority); q unchanged.
REQ-016 RUN with en=1 and counter>0: shift q one place in latched dir, fill from sr_in/sl_in sampled that cycle, decrement counter.
REQ-017 RUN with en=1 and counter=0: return to IDLE, assert done for exactly one cycle, q unchanged.
REQ-018 RUN with en=0: q, counter and state frozen; done stays 0.
REQ-019 In RUN, mode, start, amount and dir are ignored; start is not queued.
REQ-020 amount=0: RUN lasts one cycle, done pulses, no shift; amount>WIDTH is clamped to WIDTH (q fully replaced by serial input).
REQ-021 done is registered, low in all cycles except the one after REQ-017 transition.

Reset
REQ-022 reset=1 forces immediately, regardless of clock: q=RESET_VAL, state IDLE, counter=0, busy=0, done=0.
REQ-023 Reset during RUN abandons the operation with no done pulse; first edge after release samples inputs normally.

Configuration
REQ-024 Macro SHREG_ROTATE_EN defined: modes 100/101 rotate per REQ-012 (bit shifted out re-enters opposite end).
REQ-025 SHREG_ROTATE_EN undefined: modes 100/101 behave as hold; rotate logic not synthesised; all other behaviour unchanged.

Verification (WIDTH=8, default RESET_VAL)
REQ-026 Assert reset asynchronously mid-cycle -> q=0xFF, busy=0, done=0 before next edge.
REQ-027 Load 0xA5; mode=001 sr_in=0 -> 0x52; mode=010 sl_in=1 -> 0xA5; en=0 with mode=001 -> 0xA5 held.
REQ-028 Load 0x80; mode=110 -> 0xC0, again -> 0xE0.
REQ-029 q=0xA5, start amount=3 dir=0 sr_in=0 -> busy high 4 cycles, q 0x52,0x29,0x14, done single pulse as busy falls, final q=0x14; en=0 for 2 cycles mid-run extends busy by 2.
REQ-030 q=0x81, mode=100 -> 0xC0 with SHREG_ROTATE_EN, 0x81 without; amount=0 start -> done after 1 busy cycle, q unchanged; amount=12 dir=1 sl_in=0 -> q=0x00.
REQ-031 Reset asserted in second RUN cycle -> q=0xFF, busy=0, no done pulse afterwards.
